// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz host controller: state codes, winner
// encoding and the contestant key count.
package quiz_pkg;

    localparam int KEY_N = 4;
    localparam logic [2:0] WINNER_NONE = 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_FOUL    = 3'd4
    } state_t;

    // Lowest key index wins a tie; Key[0] maps to contestant 1.
    function automatic logic [2:0] prio_winner(input logic [KEY_N-1:0] rise);
        prio_winner = WINNER_NONE;
        for (int i = KEY_N - 1; i >= 0; i--) begin
            if (rise[i]) prio_winner = 3'(i + 1);
        end
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Multi-flop synchronizer plus rising-edge detector for the contestant keys.
// A key must be seen low after reset before its rise can count as a press.
module key_sync_edge
    import quiz_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N = KEY_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] rise
);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
    logic [N-1:0] prev_q, prev_d;
    logic [N-1:0] low_seen_q, low_seen_d;
    logic         run_q, run_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = key;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
        run_d  = 1'b1;
        // The first stage only holds a real sample once run_q is set.
        low_seen_d = low_seen_q | (~sync_q[0] & {N{run_q}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= '0;
            low_seen_q <= '0;
            run_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            low_seen_q <= low_seen_d;
            run_q      <= run_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & low_seen_q;

endmodule

// File: rtl/quiz_host_ctrl.sv
// Quiz host controller: round FSM, key priority and answer-beep counter.
// Define QUIZ_FOUL_DETECT_EN to latch presses made before the round opens.
module quiz_host_ctrl
    import quiz_pkg::*;
#(
    parameter int BEEP_CYCLES = 25_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Host_Start,
    input  logic       Host_Clear,
    input  logic [3:0] Key,
    input  logic [3:0] TimerL,
    output logic       Timer_Start,
    output logic [2:0] Winner,
    output logic       Foul,
    output logic       Buzzer_Answer,
    output logic [2:0] State
);

    localparam logic [24:0] BEEP_LOAD = 25'(BEEP_CYCLES - 1);

    logic [KEY_N-1:0] rise;
    logic             start_rise;

    state_t      state_q, state_d;
    logic [2:0]  winner_q, winner_d;
    logic        foul_q, foul_d;
    logic        ts_q, ts_d;
    logic        buz_q, buz_d;
    logic [24:0] cnt_q, cnt_d;
    logic        start_prev_q, start_prev_d;

    key_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .N(KEY_N)) u_keys (
        .clk  (CLK),
        .rst  (RST),
        .key  (Key),
        .rise (rise)
    );

    assign start_rise   = Host_Start & ~start_prev_q;
    assign start_prev_d = Host_Start;

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        foul_d   = foul_q;
        ts_d     = ts_q;
        buz_d    = buz_q;
        cnt_d    = cnt_q;
        if (buz_q) begin
            if (cnt_q != 25'd0) cnt_d = cnt_q - 25'd1;
            else                buz_d = 1'b0;
        end
        if (Host_Clear) begin
            state_d  = ST_IDLE;
            winner_d = WINNER_NONE;
            foul_d   = 1'b0;
            ts_d     = 1'b0;
            buz_d    = 1'b0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
`ifdef QUIZ_FOUL_DETECT_EN
                    if (|rise) begin
                        state_d  = ST_FOUL;
                        winner_d = prio_winner(rise);
                        foul_d   = 1'b1;
                        buz_d    = 1'b1;
                        cnt_d    = BEEP_LOAD;
                    end else if (start_rise) begin
                        state_d = ST_ARMED;
                        ts_d    = 1'b1;
                    end
`else
                    if (start_rise) begin
                        state_d = ST_ARMED;
                        ts_d    = 1'b1;
                    end
`endif
                end
                // A press outranks a timer expiry sampled in the same cycle.
                ST_ARMED: begin
                    if (|rise) begin
                        state_d  = ST_LOCKED;
                        winner_d = prio_winner(rise);
                        ts_d     = 1'b0;
                        buz_d    = 1'b1;
                        cnt_d    = BEEP_LOAD;
                    end else if (ts_q && TimerL == 4'd0) begin
                        state_d = ST_TIMEOUT;
                        ts_d    = 1'b0;
                    end
                end
                ST_LOCKED, ST_TIMEOUT, ST_FOUL: ;
                default: begin
                    state_d  = ST_IDLE;
                    winner_d = WINNER_NONE;
                    foul_d   = 1'b0;
                    ts_d     = 1'b0;
                    buz_d    = 1'b0;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            winner_q     <= WINNER_NONE;
            foul_q       <= 1'b0;
            ts_q         <= 1'b0;
            buz_q        <= 1'b0;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            foul_q       <= foul_d;
            ts_q         <= ts_d;
            buz_q        <= buz_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign Timer_Start   = ts_q;
    assign Winner        = winner_q;
    assign Foul          = foul_q;
    assign Buzzer_Answer = buz_q;
    assign State         = state_q;

endmodule

// File: tb/tb_quiz_host_ctrl.sv
// Directed bench for quiz_host_ctrl with BEEP_CYCLES=4, SYNC_STAGES=2.
module tb_quiz_host_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Host_Start = 1'b0;
    logic       Host_Clear = 1'b0;
    logic [3:0] Key = 4'd0;
    logic [3:0] TimerL = 4'd7;
    logic       Timer_Start;
    logic [2:0] Winner;
    logic       Foul;
    logic       Buzzer_Answer;
    logic [2:0] State;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    quiz_host_ctrl #(.BEEP_CYCLES(4), .SYNC_STAGES(2)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .Host_Start    (Host_Start),
        .Host_Clear    (Host_Clear),
        .Key           (Key),
        .TimerL        (TimerL),
        .Timer_Start   (Timer_Start),
        .Winner        (Winner),
        .Foul          (Foul),
        .Buzzer_Answer (Buzzer_Answer),
        .State         (State)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(State), 32'd0);
        check({tag, "_winner"}, 32'(Winner), 32'd0);
        check({tag, "_foul"}, 32'(Foul), 32'd0);
        check({tag, "_buzz"}, 32'(Buzzer_Answer), 32'd0);
        check({tag, "_tstart"}, 32'(Timer_Start), 32'd0);
    endtask

    // Counts high samples of Buzzer_Answer over 8 cycles, starting now.
    task automatic check_beep(input string tag, input int exp);
        int cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (Buzzer_Answer) cnt++;
            tick();
        end
        check(tag, 32'(cnt), 32'(exp));
    endtask

    task automatic clear_round();
        Host_Clear = 1'b1;
        tick();
        Host_Clear = 1'b0;
        Key = 4'd0;
        TimerL = 4'd7;
        tick(3);
    endtask

    task automatic open_round();
        Host_Start = 1'b1;
        tick();
        Host_Start = 1'b0;
    endtask

    initial begin
        tick(3);
        check_all_zero("reset");
        RST = 1'b0;
        tick(3);
        check("idle_after_reset", 32'(State), 32'd0);

        // Basic round, winner 3, latency and beep length
        open_round();
        check("armed_state", 32'(State), 32'd1);
        check("armed_tstart", 32'(Timer_Start), 32'd1);
        Key = 4'b0100;
        tick(2);
        check("latency_not_yet", 32'(Winner), 32'd0);
        tick();
        check("win3", 32'(Winner), 32'd3);
        check("win3_state", 32'(State), 32'd2);
        check("win3_tstart", 32'(Timer_Start), 32'd0);
        check_beep("win3_beep_len", 4);
        Key = 4'b0101;
        Host_Start = 1'b1;
        tick(4);
        Host_Start = 1'b0;
        check("locked_ignores_key", 32'(Winner), 32'd3);
        check("locked_ignores_start", 32'(State), 32'd2);
        clear_round();
        check_all_zero("clear1");

        // Simultaneous presses resolve to the lowest index
        open_round();
        Key = 4'b1010;
        tick(3);
        check("tie_win2", 32'(Winner), 32'd2);
        Key = 4'b1011;
        tick(4);
        check("late_key0", 32'(Winner), 32'd2);
        clear_round();

        // Timeout without any press
        open_round();
        TimerL = 4'd0;
        tick();
        check("timeout_state", 32'(State), 32'd3);
        check("timeout_winner", 32'(Winner), 32'd0);
        check("timeout_tstart", 32'(Timer_Start), 32'd0);
        check_beep("timeout_no_beep", 0);
        clear_round();

        // Press and TimerL==0 in the same cycle
        open_round();
        Key = 4'b1000;
        tick(2);
        TimerL = 4'd0;
        tick();
        check("race_state", 32'(State), 32'd2);
        check("race_winner", 32'(Winner), 32'd4);
        clear_round();

        // Host_Clear outranks a press in the same cycle
        open_round();
        Key = 4'b0001;
        tick(2);
        Host_Clear = 1'b1;
        tick();
        Host_Clear = 1'b0;
        check("clr_prio_state", 32'(State), 32'd0);
        check("clr_prio_winner", 32'(Winner), 32'd0);
        tick(3);
        check("clr_prio_stays", 32'(State), 32'd0);
        Key = 4'd0;
        tick(3);

        // Press in IDLE
        Key = 4'b0010;
        tick(3);
`ifdef QUIZ_FOUL_DETECT_EN
        check("foul_state", 32'(State), 32'd4);
        check("foul_flag", 32'(Foul), 32'd1);
        check("foul_winner", 32'(Winner), 32'd2);
        check_beep("foul_beep_len", 4);
        Key = 4'd0;
        Host_Start = 1'b1;
        tick(2);
        Host_Start = 1'b0;
        check("foul_sticky", 32'(State), 32'd4);
`else
        check("idle_press_state", 32'(State), 32'd0);
        check("idle_press_winner", 32'(Winner), 32'd0);
        check("idle_press_foul", 32'(Foul), 32'd0);
`endif
        clear_round();

        // Host_Clear on the second beep cycle
        open_round();
        Key = 4'b0001;
        tick(3);
        check("beep1", 32'(Buzzer_Answer), 32'd1);
        tick();
        check("beep2", 32'(Buzzer_Answer), 32'd1);
        Host_Clear = 1'b1;
        tick();
        Host_Clear = 1'b0;
        check_all_zero("midbeep_clear");
        check_beep("midbeep_clear_residual", 0);
        Key = 4'd0;
        tick(3);

        // RST on the second beep cycle
        open_round();
        Key = 4'b0001;
        tick(4);
        check("rbeep2", 32'(Buzzer_Answer), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_all_zero("midbeep_rst");
        check_beep("midbeep_rst_residual", 0);

        // Key held through reset must not count as a press
        Key = 4'b0100;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        open_round();
        tick(5);
        check("held_key_state", 32'(State), 32'd1);
        check("held_key_winner", 32'(Winner), 32'd0);
        Key = 4'd0;
        tick(2);
        Key = 4'b0100;
        tick(3);
        check("after_release_win", 32'(Winner), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
